// File: rtl/sr_shift_ctrl_pkg.sv
// Shared definitions for the shift-register sequencer: register mode
// encodings and controller state encoding.
package sr_shift_ctrl_pkg;

  // Mode select values understood by the 4-bit universal shift register
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sr_shift_counter.sv
// Loadable CW-bit down-counter. zero_next flags the enabled cycle whose
// closing edge takes the count from 1 to 0.
module sr_shift_counter #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          zero_next
);

  // Preload on capture, decrement once per enabled cycle, never wrap below 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - 1'b1;
  end

  assign zero_next = en && (count == CW'(1));

endmodule

// File: rtl/sr_shift_ctrl.sv
// Sequencer driving a universal shift register: one load cycle, then the
// requested number of shift cycles, then a one-cycle done pulse.
// Optional macro SR_SHIFT_CTRL_ROTATE_EN: during SHIFT, sin is taken
// combinationally from the register's outgoing bit so the word rotates.
module sr_shift_ctrl
  import sr_shift_ctrl_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          dir,
  input  logic [N-1:0]  data_in,
  input  logic          fill_bit,
  input  logic [CW-1:0] shift_count,
  input  logic [N-1:0]  sr_q,
  output logic [1:0]    s,
  output logic [N-1:0]  pin,
  output logic          sin,
  output logic          busy,
  output logic          done
);

  state_t        state, next_state;
  logic          capture;
  logic          cap_dir;
  logic          cap_fill;
  logic [CW-1:0] cnt;
  logic          cnt_zero_next;
  logic [1:0]    s_d;
  logic          busy_d;
  logic          done_d;

  assign capture = (state == ST_IDLE) && start;

  sr_shift_counter #(.CW(CW)) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .en        (state == ST_SHIFT),
    .load_val  (shift_count),
    .count     (cnt),
    .zero_next (cnt_zero_next)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (start) next_state = ST_LOAD;
      ST_LOAD:  next_state = (cnt != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (cnt_zero_next) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered copies line up
  // with the state they describe
  always_comb begin
    s_d    = MODE_HOLD;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (next_state)
      ST_IDLE:  ;
      ST_LOAD:  begin s_d = MODE_LOAD; busy_d = 1'b1; end
      ST_SHIFT: begin s_d = cap_dir ? MODE_SHL : MODE_SHR; busy_d = 1'b1; end
      ST_DONE:  begin busy_d = 1'b1; done_d = 1'b1; end
      default:  ;
    endcase
  end

  // Command capture; pin doubles as the captured word and holds until the next capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_dir  <= 1'b0;
      cap_fill <= 1'b0;
      pin      <= '0;
    end else if (capture) begin
      cap_dir  <= dir;
      cap_fill <= fill_bit;
      pin      <= data_in;
    end
  end

  // Registered mode/handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s    <= MODE_HOLD;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      s    <= s_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

`ifdef SR_SHIFT_CTRL_ROTATE_EN
  logic unused_fill;
  assign unused_fill = cap_fill;

  // Feed the outgoing bit back in so the word rotates
  always_comb begin
    sin = 1'b0;
    if (state == ST_SHIFT)
      sin = cap_dir ? sr_q[N-1] : sr_q[0];
  end
`else
  logic sin_q;
  logic unused_sr_q;
  assign unused_sr_q = ^sr_q;

  // Registered fill bit, presented only while shifting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sin_q <= 1'b0;
    else
      sin_q <= (next_state == ST_SHIFT) ? cap_fill : 1'b0;
  end

  assign sin = sin_q;
`endif

endmodule

// File: tb/tb_sr_shift_ctrl.sv
module tb_sr_shift_ctrl;

  localparam int N  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic          fill_bit = 1'b0;
  logic [N-1:0]  data_in = '0;
  logic [CW-1:0] shift_count = '0;
  logic [N-1:0]  sr_q = '0;
  logic [1:0]    s;
  logic [N-1:0]  pin;
  logic          sin;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic [1:0]   s;
    logic         busy;
    logic         done;
    logic         sin;
    logic [N-1:0] pin;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_shift_ctrl #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .dir         (dir),
    .data_in     (data_in),
    .fill_bit    (fill_bit),
    .shift_count (shift_count),
    .sr_q        (sr_q),
    .s           (s),
    .pin         (pin),
    .sin         (sin),
    .busy        (busy),
    .done        (done)
  );

  // Behavioural 4-bit universal shift register driven by the controller
  always @(posedge clk) begin
    case (s)
      2'b01: sr_q <= {sin, sr_q[N-1:1]};
      2'b10: sr_q <= {sr_q[N-2:0], sin};
      2'b11: sr_q <= pin;
      default: sr_q <= sr_q;
    endcase
  end

  function automatic logic [N-1:0] model_result(logic [N-1:0] d, logic dr, logic f, int c);
    logic [N-1:0] r;
    r = d;
    for (int i = 0; i < c; i++) begin
`ifdef SR_SHIFT_CTRL_ROTATE_EN
      r = dr ? {r[N-2:0], r[N-1]} : {r[0], r[N-1:1]};
`else
      r = dr ? {r[N-2:0], f} : {f, r[N-1:1]};
`endif
    end
    return r;
  endfunction

  function automatic void push_cmd(logic [N-1:0] d, logic dr, logic f, int c);
    sb.push_back('{2'b11, 1'b1, 1'b0, 1'b0, d});
    for (int i = 0; i < c; i++)
      sb.push_back('{(dr ? 2'b10 : 2'b01), 1'b1, 1'b0, f, d});
    sb.push_back('{2'b00, 1'b1, 1'b1, 1'b0, d});
  endfunction

  // Issue one command, drain the scoreboard cycle by cycle, then check the
  // idle state and the resulting register word. glitch = cycle index at
  // which a conflicting start is injected (0 = none).
  task automatic run_cmd(input string name, input logic [N-1:0] d, input logic dr,
                         input logic f, input int c, input logic [N-1:0] exp_reg,
                         input int glitch);
    exp_t e, got;
    int cyc;
    @(negedge clk);
    data_in = d; dir = dr; fill_bit = f; shift_count = CW'(c); start = 1'b1;
    push_cmd(d, dr, f, c);
    @(posedge clk); #1;
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = '{s, busy, done, sin, pin};
`ifdef SR_SHIFT_CTRL_ROTATE_EN
      got.sin = 1'b0;
      e.sin = 1'b0;
`endif
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s cyc%0d: got s=%b busy=%b done=%b sin=%b pin=%b, expected s=%b busy=%b done=%b sin=%b pin=%b",
                 name, cyc, got.s, got.busy, got.done, got.sin, got.pin,
                 e.s, e.busy, e.done, e.sin, e.pin);
      end
      cyc++;
      @(negedge clk);
      start = (cyc == glitch);
      data_in = N'($urandom);
      dir = 1'($urandom);
      fill_bit = 1'($urandom);
      shift_count = CW'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== 2'b00) begin
      failures++;
      $display("FAIL %s_idle: got busy=%b done=%b s=%b, expected 0 0 00", name, busy, done, s);
    end
    checks++;
    if (sr_q !== exp_reg) begin
      failures++;
      $display("FAIL %s_reg: got %b, expected %b", name, sr_q, exp_reg);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (s !== 2'b00 || pin !== '0 || sin !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got s=%b pin=%b sin=%b busy=%b done=%b, expected all zero",
               s, pin, sin, busy, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
`ifndef SR_SHIFT_CTRL_ROTATE_EN
    run_cmd("shr_cnt2", 4'b1011, 1'b0, 1'b0, 2, 4'b0010, 0);
    run_cmd("shl_cnt3_fill1", 4'b1011, 1'b1, 1'b1, 3, 4'b1111, 0);
`endif
    run_cmd("cnt0", 4'b0110, 1'b0, 1'b1, 0, 4'b0110, 0);
  endtask

  task automatic test_ignore_start();
`ifndef SR_SHIFT_CTRL_ROTATE_EN
    run_cmd("start_while_busy", 4'b1011, 1'b0, 1'b0, 2, 4'b0010, 2);
`else
    run_cmd("start_while_busy", 4'b1001, 1'b0, 1'b0, 2, 4'b0110, 2);
`endif
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    data_in = 4'b1011; dir = 1'b0; fill_bit = 1'b1; shift_count = 3'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || sin !== 1'b0 || pin !== '0) begin
      failures++;
      $display("FAIL reset_mid_shift: got s=%b busy=%b done=%b sin=%b pin=%b, expected all zero",
               s, busy, done, sin, pin);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (s !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle%0d: got s=%b busy=%b done=%b, expected 00 0 0", i, s, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    int cyc;
    logic [N-1:0] ra, rb;
    ra = model_result(4'b1011, 1'b0, 1'b0, 1);
    rb = model_result(4'b1100, 1'b1, 1'b1, 2);
    @(negedge clk);
    data_in = 4'b1011; dir = 1'b0; fill_bit = 1'b0; shift_count = 3'd1; start = 1'b1;
    push_cmd(4'b1011, 1'b0, 1'b0, 1);
    sb.push_back('{2'b00, 1'b0, 1'b0, 1'b0, 4'b1011});
    push_cmd(4'b1100, 1'b1, 1'b1, 2);
    @(posedge clk); #1;
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = '{s, busy, done, sin, pin};
`ifdef SR_SHIFT_CTRL_ROTATE_EN
      got.sin = 1'b0;
      e.sin = 1'b0;
`endif
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL back_to_back cyc%0d: got s=%b busy=%b done=%b sin=%b pin=%b, expected s=%b busy=%b done=%b sin=%b pin=%b",
                 cyc, got.s, got.busy, got.done, got.sin, got.pin,
                 e.s, e.busy, e.done, e.sin, e.pin);
      end
      if (cyc == 3) begin
        checks++;
        if (sr_q !== ra) begin
          failures++;
          $display("FAIL back_to_back_first_reg: got %b, expected %b", sr_q, ra);
        end
      end
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        data_in = 4'b1100; dir = 1'b1; fill_bit = 1'b1; shift_count = 3'd2;
      end
      if (cyc == 5) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (sr_q !== rb || busy !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_second: got reg=%b busy=%b, expected reg=%b busy=0", sr_q, busy, rb);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] d;
    logic dr, f;
    int c;
    for (int i = 0; i < 8; i++) begin
      d  = N'($urandom);
      dr = 1'($urandom);
      f  = 1'($urandom);
      c  = (i == 0) ? 7 : int'($urandom_range(0, 7));
      run_cmd($sformatf("random%0d", i), d, dr, f, c, model_result(d, dr, f, c), 0);
    end
  endtask

`ifdef SR_SHIFT_CTRL_ROTATE_EN
  task automatic test_rotate();
    run_cmd("rotate_cnt4", 4'b1001, 1'b0, 1'b0, 4, 4'b1001, 0);
    run_cmd("rotate_cnt1", 4'b1001, 1'b0, 1'b0, 1, 4'b1100, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
`ifdef SR_SHIFT_CTRL_ROTATE_EN
    test_rotate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_shift_ctrl.md
Name: sr_shift_ctrl

Overview:
- Sequencer placed directly upstream of the 4-bit universal shift register (modes: 00 hold, 01 shift right with sin into MSB, 10 shift left with sin into LSB, 11 parallel load).
- Accepts a command (word, direction, shift count, fill bit) through a start/busy handshake.
- Drives the register's s, pin and sin: one load cycle, then exactly the requested number of shift cycles, then hold.
- Pulses done when the sequence completes.

Parameters:
- N, 4, data width; must match the shift register width.
- CW, 3, width of the shift-count field; shift counts range 0..2^CW-1.

Ports:
- clk  input  1  rising-edge clock, shared with the shift register
- reset  input  1  asynchronous active-low reset
- start  input  1  command request, sampled only in IDLE
- dir  input  1  0 = shift right (mode 01), 1 = shift left (mode 10)
- data_in  input  N  word to load
- fill_bit  input  1  serial bit fed in during shifts
- shift_count  input  CW  number of shift cycles after the load
- sr_q  input  N  current shift-register contents; used only with ROTATE_EN
- s  output  2  mode select to the shift register
- pin  output  N  parallel load word to the shift register
- sin  output  1  serial input to the shift register
- busy  output  1  high while a command is in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous, active-low, and may assert at any time, including mid-sequence.
  - During reset: state = IDLE, s = 00, pin = 0, sin = 0, busy = 0, done = 0, counter = 0, captured command cleared.
  - After reset releases, the block waits in IDLE for a new start.
- Outputs s, pin, busy and done are registered. sin is registered except under ROTATE_EN (see below).
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - s = 00, busy = 0.
  - If start = 1 at a clock edge: capture dir, data_in, fill_bit and shift_count; go to LOAD.
- LOAD (exactly 1 cycle):
  - s = 11, pin = captured word, busy = 1.
  - The register loads at the edge that ends this cycle.
  - Next state: SHIFT if captured count > 0, otherwise DONE.
- SHIFT (exactly count cycles):
  - s = 01 if dir = 0, s = 10 if dir = 1; sin = captured fill_bit.
  - Counter is preloaded with count and decrements once per cycle.
  - Leaves for DONE on the edge where the counter goes 1 -> 0.
  - Counts greater than N are legal; the extra shifts keep inserting fill bits.
- DONE (exactly 1 cycle):
  - s = 00, done = 1, busy = 1.
  - Next state: IDLE.
- Latency: start edge to done = count + 2 cycles. The next start can be accepted in the cycle after done.
- pin holds the captured word from LOAD until the next capture. It is ignored by the register outside mode 11.
- start while busy is ignored, with no queuing.
- Input changes after capture have no effect on the sequence in progress.
- start held continuously: a new command is captured in every IDLE cycle (back-to-back operation).

Optional Feature:
- Macro: SR_SHIFT_CTRL_ROTATE_EN.
- Defined:
  - During SHIFT, sin is driven combinationally: sr_q[0] when dir = 0, sr_q[N-1] when dir = 1. The word therefore rotates.
  - fill_bit is captured but unused.
  - Outside SHIFT, sin = 0.
- Undefined:
  - sin = captured fill_bit during SHIFT.
  - sr_q is unconnected internally.

Decomposition:
- Shared package holds:
  - mode constants: MODE_HOLD = 2'b00, MODE_SHR = 2'b01, MODE_SHL = 2'b10, MODE_LOAD = 2'b11
  - state encoding constants for IDLE, LOAD, SHIFT and DONE
- One natural sub-module: sr_shift_counter.
  - Loadable CW-bit down-counter with load, enable and a zero-next flag.
  - Instantiated once.

Test Plan (N = 4, CW = 3, controller wired to the shift register):
1. data_in = 1011, dir = 0, fill = 0, count = 2, start pulse:
   - s sequence 11, 01, 01, 00; done on cycle 4; register = 0010.
2. data_in = 1011, dir = 1, fill = 1, count = 3:
   - s sequence 11, 10, 10, 10, 00; register = 1111; busy high for 5 cycles.
3. count = 0, data_in = 0110:
   - s sequence 11, 00; done on cycle 2; register = 0110.
4. start pulsed again during SHIFT with different data:
   - ignored; register result and done timing identical to scenario 1.
5. reset asserted mid-SHIFT (count = 5):
   - s = 00, busy = 0, done = 0 immediately.
   - After release, no activity until the next start.
6. ROTATE_EN, data_in = 1001, dir = 0, count = 4:
   - register returns to 1001; with count = 1, register = 1100.
